// File: rtl/cu_mem_sram_ctrl_pkg.sv
`default_nettype none
////////////////////////////////////////////////////////////////////////
// cu_mem_pkg -- shared types and constants for the CU SRAM controller
// Revision 1.0
////////////////////////////////////////////////////////////////////////
package cu_mem_pkg;

  localparam int LANES  = 4;
  localparam int BYTE_W = 8;

  typedef logic [1:0] lane_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cu_mem_sram_ctrl_if.sv
`default_nettype none
////////////////////////////////////////////////////////////////////////
// cu_mem_sram_ctrl_if -- request/response and byte-SRAM bus bundle
// Revision 1.0
////////////////////////////////////////////////////////////////////////
interface cu_mem_sram_ctrl_if
  import cu_mem_pkg::*;
#(
  parameter int ADDR_W = 7
);

  logic                      req_valid;
  logic                      req_ready;
  logic [ADDR_W-1:0]         req_addr;
  logic [LANES-1:0]          req_be;
  logic                      req_write;
  logic [LANES*BYTE_W-1:0]   req_wdata;
  logic                      rsp_valid;
  logic [LANES*BYTE_W-1:0]   rsp_rdata;
  logic                      rsp_err;
  logic                      sram_en;
  logic                      sram_we;
  logic [ADDR_W-1:0]         sram_addr;
  logic [BYTE_W-1:0]         sram_wdata;
  logic [BYTE_W-1:0]         sram_rdata;

  // master: memory stage plus the SRAM macro; slave: the controller
  modport master (
    output req_valid, req_addr, req_be, req_write, req_wdata, sram_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           sram_en, sram_we, sram_addr, sram_wdata
  );

  modport slave (
    input  req_valid, req_addr, req_be, req_write, req_wdata, sram_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           sram_en, sram_we, sram_addr, sram_wdata
  );

endinterface
`default_nettype wire

// File: rtl/cu_mem_sram_ctrl_lane_sel.sv
`default_nettype none
////////////////////////////////////////////////////////////////////////
// cu_mem_lane_sel -- lowest-set-bit priority encoder over the lane mask
// Revision 1.0
////////////////////////////////////////////////////////////////////////
module cu_mem_lane_sel
  import cu_mem_pkg::*;
(
  input  logic [LANES-1:0] mask,
  output lane_idx_t        lane,
  output logic [LANES-1:0] lane_oh,
  output logic             any_left
);

  // Scan downwards so the lowest set bit is the last one to win
  always_comb begin
    lane     = '0;
    lane_oh  = '0;
    any_left = |mask;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask[i]) begin
        lane       = lane_idx_t'(i);
        lane_oh    = '0;
        lane_oh[i] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cu_mem_sram_ctrl.sv
`default_nettype none
////////////////////////////////////////////////////////////////////////
// cu_mem_sram_ctrl -- byte-serial SRAM access controller for the CU memory stage
// Revision 1.0
////////////////////////////////////////////////////////////////////////
module cu_mem_sram_ctrl #(
  parameter int ADDR_W = 7,
  parameter int LANES  = 4
) (
  input  logic              soc_clk,
  input  logic              MEM_reset_reg,
  cu_mem_sram_ctrl_if.slave bus
);
  import cu_mem_pkg::*;

  localparam int WORD_W = LANES * BYTE_W;

  state_t            state_q, state_d;
  logic [ADDR_W-3:0] waddr_q, waddr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              write_q, write_d;
  logic              err_q,   err_d;
  logic [LANES-1:0]  mask_q,  mask_d;
  lane_idx_t         lane_q,  lane_d;

  lane_idx_t         sel_lane;
  logic [LANES-1:0]  sel_oh;
  logic              sel_any;
  logic              accept;

  cu_mem_lane_sel u_lane_sel (
    .mask     (mask_q),
    .lane     (sel_lane),
    .lane_oh  (sel_oh),
    .any_left (sel_any)
  );

  // Reset gates ready directly so it reads 0 for the whole reset window
  assign bus.req_ready = (state_q == ST_IDLE) & ~MEM_reset_reg;
  assign accept        = bus.req_valid & bus.req_ready;

  always_comb begin
    state_d        = state_q;
    waddr_d        = waddr_q;
    wdata_d        = wdata_q;
    rdata_d        = rdata_q;
    write_d        = write_q;
    err_d          = err_q;
    mask_d         = mask_q;
    lane_d         = lane_q;
    bus.rsp_valid  = 1'b0;
    bus.rsp_rdata  = '0;
    bus.rsp_err    = 1'b0;
    bus.sram_en    = 1'b0;
    bus.sram_we    = 1'b0;
    bus.sram_addr  = '0;
    bus.sram_wdata = '0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rdata_d = '0;
          if ((bus.req_be == '0) || (bus.req_addr[1:0] != 2'b00)) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            err_d   = 1'b0;
            waddr_d = bus.req_addr[ADDR_W-1:2];
            wdata_d = bus.req_wdata;
            write_d = bus.req_write;
            mask_d  = bus.req_be;
            state_d = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        bus.sram_en    = 1'b1;
        bus.sram_we    = write_q;
        bus.sram_addr  = {waddr_q, sel_lane};
        bus.sram_wdata = wdata_q[BYTE_W*sel_lane +: BYTE_W];
        mask_d         = mask_q & ~sel_oh;
        lane_d         = sel_lane;
        if (write_q) begin
          state_d = (|mask_d) ? ST_ISSUE : ST_RESP;
        end else begin
          state_d = ST_CAPTURE;
        end
      end

      ST_CAPTURE: begin
        // The SRAM returns the byte one cycle after the read strobe
        rdata_d[BYTE_W*lane_q +: BYTE_W] = bus.sram_rdata;
        state_d = sel_any ? ST_ISSUE : ST_RESP;
      end

      ST_RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_rdata = rdata_q;
        bus.rsp_err   = err_q;
        state_d       = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge soc_clk or posedge MEM_reset_reg) begin
    if (MEM_reset_reg) begin
      state_q <= ST_IDLE;
      waddr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      mask_q  <= '0;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      write_q <= write_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
      lane_q  <= lane_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cu_mem_sram_ctrl.sv
`default_nettype none
////////////////////////////////////////////////////////////////////////
// tb_cu_mem_sram_ctrl -- self-checking bench for cu_mem_sram_ctrl
// Revision 1.0
////////////////////////////////////////////////////////////////////////
module tb_cu_mem_sram_ctrl;

  localparam int ADDR_W = 7;

  typedef struct {
    logic [6:0]  addr;
    logic [3:0]  be;
    logic        wr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
    int          lat;
  } vec_t;

  logic soc_clk = 1'b0;
  logic rst     = 1'b1;
  logic sram_clr = 1'b1;

  always #5 soc_clk = ~soc_clk;

  cu_mem_sram_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  cu_mem_sram_ctrl #(.ADDR_W(ADDR_W), .LANES(4)) dut (
    .soc_clk       (soc_clk),
    .MEM_reset_reg (rst),
    .bus           (bus)
  );

  // Byte-wide synchronous SRAM with one-cycle read latency
  logic [7:0] sram_mem [128];
  logic [7:0] sram_rd_q = 8'h00;
  always @(posedge soc_clk) begin
    if (sram_clr) begin
      for (int i = 0; i < 128; i++) sram_mem[i] <= 8'h00;
    end else if (bus.sram_en) begin
      if (bus.sram_we) sram_mem[bus.sram_addr] <= bus.sram_wdata;
      else             sram_rd_q <= sram_mem[bus.sram_addr];
    end
  end
  assign bus.sram_rdata = sram_rd_q;

  // Strobe log {we, addr, data(writes only)} and response pulse counter
  logic [15:0] strobe_q [$];
  int          rsp_pulses = 0;
  always @(posedge soc_clk) begin
    if (bus.sram_en)
      strobe_q.push_back({bus.sram_we, bus.sram_addr, bus.sram_we ? bus.sram_wdata : 8'h00});
    if (bus.rsp_valid) rsp_pulses <= rsp_pulses + 1;
  end

  logic [7:0] ref_mem [128];
  int n_pass  = 0;
  int n_total = 0;
  int n_req   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // One transaction; expectations come from the table (use_tbl) or the reference model
  task automatic do_req(input string tag, input logic [6:0] a, input logic [3:0] be,
                        input logic wr, input logic [31:0] wd, input bit use_tbl,
                        input logic [31:0] t_rd, input logic t_err, input int t_lat);
    logic [31:0] m_rd;
    logic        m_err;
    int          m_lat, k, w, n, base, got_n;
    bit          got;
    logic [15:0] ex [$];
    logic [31:0] g_rd;
    logic        g_err;

    m_rd  = 32'h0;
    m_err = (be == 4'h0) || ((a % 4) != 0);
    k     = $countones(be);
    m_lat = m_err ? 1 : (wr ? k + 1 : 2 * k + 1);
    if (!m_err) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) begin
          logic [6:0] ba;
          logic [7:0] bv;
          ba = a + 7'(l);
          bv = wd[8*l +: 8];
          if (wr) begin
            ex.push_back({1'b1, ba, bv});
            ref_mem[ba] = bv;
          end else begin
            ex.push_back({1'b0, ba, 8'h00});
            m_rd[8*l +: 8] = ref_mem[ba];
          end
        end
      end
    end

    @(negedge soc_clk);
    w = 0;
    while (!bus.req_ready && w < 50) begin
      @(negedge soc_clk);
      w++;
    end
    if (!bus.req_ready) begin
      chk({tag, " ready timeout"}, 32'h0, 32'h1);
      return;
    end
    bus.req_addr  = a;
    bus.req_be    = be;
    bus.req_write = wr;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    base = strobe_q.size();
    n_req++;
    @(posedge soc_clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = 7'($urandom);
    bus.req_be    = 4'($urandom);
    bus.req_write = 1'($urandom);
    bus.req_wdata = $urandom;

    n = 0;
    got = 0;
    g_rd = 32'h0;
    g_err = 1'b0;
    while (n < 40 && !got) begin
      @(negedge soc_clk);
      n++;
      if (bus.rsp_valid) begin
        got   = 1;
        g_rd  = bus.rsp_rdata;
        g_err = bus.rsp_err;
      end
    end
    if (!got) begin
      chk({tag, " rsp timeout"}, 32'h0, 32'h1);
      return;
    end
    chk({tag, " rdata"},   g_rd,        use_tbl ? t_rd : m_rd);
    chk({tag, " err"},     32'(g_err),  32'(use_tbl ? t_err : m_err));
    chk({tag, " latency"}, 32'(n),      32'(use_tbl ? t_lat : m_lat));
    @(negedge soc_clk);
    chk({tag, " rsp one cycle/idle"}, {30'h0, bus.rsp_valid, bus.req_ready}, 32'h1);
    got_n = strobe_q.size() - base;
    chk({tag, " strobe count"}, 32'(got_n), 32'(ex.size()));
    for (int i = 0; i < ex.size() && i < got_n; i++)
      chk({tag, " strobe"}, {16'h0, strobe_q[base + i]}, {16'h0, ex[i]});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t        vecs [12];
    int          base, p0, n_b2b;
    int          rc [$];
    logic [31:0] rd_b;
    logic        rdy3, rdy6;

    vecs[0]  = '{7'h10, 4'hF, 1'b1, 32'hDEADBEEF, 32'h00000000, 1'b0, 5};
    vecs[1]  = '{7'h10, 4'hF, 1'b0, 32'h00000000, 32'hDEADBEEF, 1'b0, 9};
    vecs[2]  = '{7'h20, 4'h4, 1'b1, 32'h00AA0000, 32'h00000000, 1'b0, 2};
    vecs[3]  = '{7'h20, 4'hF, 1'b0, 32'h00000000, 32'h00AA0000, 1'b0, 9};
    vecs[4]  = '{7'h10, 4'hA, 1'b0, 32'h00000000, 32'hDE00BE00, 1'b0, 5};
    vecs[5]  = '{7'h10, 4'h0, 1'b0, 32'h00000000, 32'h00000000, 1'b1, 1};
    vecs[6]  = '{7'h13, 4'hF, 1'b1, 32'h12345678, 32'h00000000, 1'b1, 1};
    vecs[7]  = '{7'h7C, 4'h8, 1'b1, 32'h55000000, 32'h00000000, 1'b0, 2};
    vecs[8]  = '{7'h7C, 4'hF, 1'b0, 32'h00000000, 32'h55000000, 1'b0, 9};
    vecs[9]  = '{7'h7D, 4'h2, 1'b0, 32'h00000000, 32'h00000000, 1'b1, 1};
    vecs[10] = '{7'h14, 4'h5, 1'b1, 32'h11223344, 32'h00000000, 1'b0, 3};
    vecs[11] = '{7'h14, 4'hF, 1'b0, 32'h00000000, 32'h00220044, 1'b0, 9};

    for (int i = 0; i < 128; i++) ref_mem[i] = 8'h00;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_be    = '0;
    bus.req_write = 1'b0;
    bus.req_wdata = '0;

    repeat (3) @(negedge soc_clk);
    chk("reset rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("reset ctrl", {27'h0, bus.rsp_valid, bus.rsp_err, bus.sram_en, bus.sram_we, bus.req_ready}, 32'h0);
    chk("reset sram bus", {17'h0, bus.sram_addr, bus.sram_wdata}, 32'h0);
    rst      = 1'b0;
    sram_clr = 1'b0;
    #1;
    chk("ready after reset", {31'h0, bus.req_ready}, 32'h1);

    for (int i = 0; i < 12; i++)
      do_req($sformatf("vec%0d", i), vecs[i].addr, vecs[i].be, vecs[i].wr, vecs[i].wd,
             1, vecs[i].rd, vecs[i].err, vecs[i].lat);

    for (int t = 0; t < 40; t++) begin
      logic [6:0] ra;
      ra = ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'($urandom_range(0, 31) * 4);
      do_req("rand", ra, 4'($urandom), 1'($urandom), $urandom, 0, 32'h0, 1'b0, 0);
    end

    // Abort a full-word store after its second byte has been written
    @(negedge soc_clk);
    bus.req_addr  = 7'h40;
    bus.req_be    = 4'hF;
    bus.req_write = 1'b1;
    bus.req_wdata = 32'h11223344;
    bus.req_valid = 1'b1;
    base = strobe_q.size();
    p0   = rsp_pulses;
    @(posedge soc_clk);
    #1 bus.req_valid = 1'b0;
    @(posedge soc_clk);
    @(posedge soc_clk);
    #2;
    chk("pre-reset sram_en", {31'h0, bus.sram_en}, 32'h1);
    rst = 1'b1;
    #1;
    chk("async reset drop", {29'h0, bus.sram_en, bus.sram_we, bus.req_ready}, 32'h0);
    repeat (2) @(negedge soc_clk);
    rst = 1'b0;
    #1;
    chk("ready after abort", {31'h0, bus.req_ready}, 32'h1);
    chk("abort no rsp", 32'(rsp_pulses), 32'(p0));
    chk("abort strobes", 32'(strobe_q.size() - base), 32'd2);
    ref_mem[7'h40] = 8'h44;
    ref_mem[7'h41] = 8'h33;
    do_req("post-abort load", 7'h40, 4'hF, 1'b0, 32'h0, 0, 32'h0, 1'b0, 0);

    // Two requests presented back-to-back with req_valid held high
    @(negedge soc_clk);
    while (!bus.req_ready) @(negedge soc_clk);
    bus.req_addr  = 7'h50;
    bus.req_be    = 4'hF;
    bus.req_write = 1'b1;
    bus.req_wdata = 32'hCAFEF00D;
    bus.req_valid = 1'b1;
    @(posedge soc_clk);
    #1;
    bus.req_write = 1'b0;
    bus.req_wdata = 32'h0;
    for (int b = 0; b < 4; b++) ref_mem[7'h50 + 7'(b)] = 8'(32'hCAFEF00D >> (8 * b));
    rd_b = 32'h0;
    rdy3 = 1'b1;
    rdy6 = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge soc_clk);
      if (bus.rsp_valid) begin
        rc.push_back(n);
        rd_b = bus.rsp_rdata;
      end
      if (n == 3) rdy3 = bus.req_ready;
      if (n == 6) rdy6 = bus.req_ready;
      if (n == 7) bus.req_valid = 1'b0;
    end
    n_b2b = rc.size();
    chk("b2b busy not ready", {31'h0, rdy3}, 32'h0);
    chk("b2b idle ready", {31'h0, rdy6}, 32'h1);
    chk("b2b rsp count", 32'(n_b2b), 32'd2);
    if (n_b2b == 2) begin
      chk("b2b first rsp cycle", 32'(rc[0]), 32'd5);
      chk("b2b second rsp cycle", 32'(rc[1]), 32'd15);
    end
    chk("b2b load data", rd_b, 32'hCAFEF00D);
    chk("total rsp pulses", 32'(rsp_pulses), 32'(n_req + 2));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
